stream_box_filter: RTL



---
 rtl/stream_box_filter_pkg.sv | 24 ++
 rtl/stream_box_filter_line_buffer.sv | 27 ++
 rtl/stream_box_filter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/stream_box_filter_pkg.sv
// Shared types and helpers for the streaming 3x3 box filter.
package stream_box_filter_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Nine PW-bit taps need four extra bits to hold their sum without overflow.
    function automatic int sum_width(input int pw);
        return pw + 4;
    endfunction

    // Lookahead counter runs 0 .. WIDTH*HEIGHT+WIDTH inclusive.
    function automatic int count_width(input int width, input int height);
        return $clog2(width * height + width + 1);
    endfunction

    // Constant division by nine, purely combinational.
    function automatic logic [31:0] div9(input logic [31:0] sum);
        return sum / 32'd9;
    endfunction

endpackage

// File: rtl/stream_box_filter_line_buffer.sv
// One-row delay line: shifts a pixel in on each enable and presents the
// pixel written WIDTH enables ago.
module stream_box_filter_line_buffer #(
    parameter int WIDTH = 400,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [WIDTH];

    // Shift the whole row one slot on every window advance.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < WIDTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[WIDTH-1];

endmodule

// File: rtl/stream_box_filter.sv
// Streaming 3x3 box-blur with zero padding at all borders and a centre-pixel
// bypass mode. Two line buffers feed a 3x3 window; the output register is
// loaded from the window as it would look after the current advance.
module stream_box_filter
    import stream_box_filter_pkg::*;
#(
    parameter int WIDTH  = 400,
    parameter int HEIGHT = 300,
    parameter int PW     = 4,
    parameter int CH     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*PW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH*PW-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int DW = CH * PW;
    localparam int SW = sum_width(PW);
    localparam int KW = count_width(WIDTH, HEIGHT);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    localparam logic [KW-1:0] K_LAST_PIXEL = KW'(WIDTH * HEIGHT - 1);
    localparam logic [KW-1:0] K_LAST       = KW'(WIDTH * HEIGHT + WIDTH);
    localparam logic [KW-1:0] K_FIRST_OUT  = KW'(WIDTH + 1);
    localparam logic [CW-1:0] COL_LAST     = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(HEIGHT - 1);

    state_t        state;
    state_t        state_next;
    logic [KW-1:0] k;
    logic [CW-1:0] cc;
    logic [RW-1:0] cr;
    logic          mode_q;
    logic          slot_free;
    logic          advance;
    logic          emit;
    logic [DW-1:0] shift_in;
    logic [DW-1:0] lb0_out;
    logic [DW-1:0] lb1_out;
    logic [DW-1:0] col_n [3];
    logic [DW-1:0] win_a [3];
    logic [DW-1:0] win_b [3];
    logic [DW-1:0] result;
    logic [SW-1:0] sum;
    logic          row_on;

    stream_box_filter_line_buffer #(.WIDTH(WIDTH), .DW(DW)) u_lb0 (
        .clk  (clk),
        .en   (advance),
        .din  (shift_in),
        .dout (lb0_out)
    );

    stream_box_filter_line_buffer #(.WIDTH(WIDTH), .DW(DW)) u_lb1 (
        .clk  (clk),
        .en   (advance),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    // State register; a reset mid-frame drops straight back to RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Enter FLUSH after the last real pixel, leave it after the last virtual one.
    always_comb begin
        state_next = state;
        if (advance) begin
            if (state == RUN && k == K_LAST_PIXEL) begin
                state_next = FLUSH;
            end else if (state == FLUSH && k == K_LAST) begin
                state_next = RUN;
            end
        end
    end

    // Handshake, advance qualification and the pixel shifted into the window.
    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = (state == RUN) && slot_free;
        advance   = (state == RUN) ? (in_valid && in_ready) : slot_free;
        emit      = advance && (k >= K_FIRST_OUT);
        shift_in  = (state == RUN) ? in_data : '0;
        busy      = (k != '0) || (state == FLUSH);
        col_n[0]  = lb1_out;
        col_n[1]  = lb0_out;
        col_n[2]  = shift_in;
    end

    // Lookahead index and centre coordinates; the centre only moves when a pixel is emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            k  <= '0;
            cc <= '0;
            cr <= '0;
        end else if (advance) begin
            k <= (k == K_LAST) ? '0 : k + KW'(1);
            if (emit) begin
                if (cc == COL_LAST) begin
                    cc <= '0;
                    cr <= (cr == ROW_LAST) ? '0 : cr + RW'(1);
                end else begin
                    cc <= cc + CW'(1);
                end
            end
        end
    end

    // Mode is captured on the first advance of a frame and held for the whole frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= 1'b0;
        end else if (advance && k == '0) begin
            mode_q <= mode;
        end
    end

    // Window columns: win_a is two advances old, win_b one advance old.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int r = 0; r < 3; r++) begin
                win_a[r] <= win_b[r];
                win_b[r] <= col_n[r];
            end
        end
    end

    // Masked per-channel 3x3 sum divided by nine, or the raw centre in bypass.
    always_comb begin
        result = '0;
        sum    = '0;
        row_on = 1'b0;
        for (int ch = 0; ch < CH; ch++) begin
            sum = '0;
            for (int r = 0; r < 3; r++) begin
                row_on = !((r == 0 && cr == '0) || (r == 2 && cr == ROW_LAST));
                if (row_on) begin
                    if (cc != '0) begin
                        sum = sum + SW'(win_a[r][ch*PW +: PW]);
                    end
                    sum = sum + SW'(win_b[r][ch*PW +: PW]);
                    if (cc != COL_LAST) begin
                        sum = sum + SW'(col_n[r][ch*PW +: PW]);
                    end
                end
            end
            result[ch*PW +: PW] = mode_q ? win_b[1][ch*PW +: PW] : PW'(div9(32'(sum)));
        end
    end

    // Output register reloads on every emitting advance, otherwise drains on handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_last  <= (cc == COL_LAST) && (cr == ROW_LAST);
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
